// File: rtl/ct_f_spsram_8192x32.sv
// Initiator-side controller for the 8192x32 single-port SRAM wrapper.
// Clears the array after reset, then turns one valid/ready request per
// cycle into an SRAM pin access. Read data comes back through a 2-entry
// response FIFO with valid/ready back-pressure.
module ct_f_spsram_8192x32_ctrl #(
    parameter int          ADDR_WIDTH = 13,
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [31:0]           rsp_rdata,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [31:0]           sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [31:0]           sram_d,
    input  logic [31:0]           sram_q
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] init_addr_reg;
    logic                  init_done_reg;
    logic [ADDR_WIDTH-1:0] a_reg;
    logic [31:0]           d_reg;
    logic                  inflight_reg;
    logic [1:0]            count_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [31:0]           buf_mem [2];

    logic        req_fire;
    logic        push;
    logic        pop;
    logic [2:0]  used_slots;
    logic [31:0] be_mask;

    // Expand byte enables into active-low per-bit write enables.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign be_mask[8*gi +: 8] = {8{~req_be[gi]}};
        end
    endgenerate

    assign push       = inflight_reg;
    assign pop        = (count_reg != 2'd0) && rsp_rdy;
    assign used_slots = {1'b0, count_reg} + {2'b00, inflight_reg};

    // A slot is free when buffered + in-flight reads leave room. When the
    // in-flight read lands in the same cycle a response leaves, the slot it
    // would have needed is freed, which keeps streaming reads at full rate.
    assign req_rdy   = (state_reg == ST_RUN) &&
                       ((used_slots < 3'd2) || (inflight_reg && pop));
    assign req_fire  = req_vld && req_rdy;
    assign rsp_vld   = (count_reg != 2'd0);
    assign rsp_rdata = buf_mem[rd_ptr_reg];
    assign init_done = init_done_reg;

    // Sequencer: one IDLE cycle, optional array clear, then normal service.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            init_addr_reg <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (INIT_EN) begin
                        state_reg <= ST_INIT;
                    end else begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                ST_INIT: begin
                    init_addr_reg <= init_addr_reg + ADDR_ONE;
                    if (&init_addr_reg) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // SRAM pins: init engine, accepted request, or idle with a/d held.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_reg;
        sram_d    = d_reg;
        if (state_reg == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_addr_reg;
            sram_d    = INIT_VALUE;
        end else if (req_fire) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = be_mask;
                sram_d    = req_wdata;
            end
        end
    end

    // Remember the last driven address/data so idle cycles hold them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg <= '0;
            d_reg <= '0;
        end else begin
            a_reg <= sram_a;
            d_reg <= sram_d;
        end
    end

    // Track the read whose data appears on sram_q next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= req_fire && !req_wr;
        end
    end

    // Two-entry response FIFO; simultaneous push and pop keep order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr_reg] <= sram_q;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_8192x32_ctrl.sv
// Directed bench for the SRAM controller with a behavioural SRAM model.
module tb_ct_f_spsram_8192x32_ctrl;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        sram_cen;
    logic        sram_gwen;
    logic [31:0] sram_wen;
    logic [12:0] sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    int n_cmp;
    int n_bad;

    logic [31:0] mem [8192];

    ct_f_spsram_8192x32_ctrl #(
        .ADDR_WIDTH (13),
        .INIT_EN    (1'b1),
        .INIT_VALUE (32'h0)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: bit-masked write, Q one cycle after read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        step();
        req_vld = 1'b0; req_wr = 1'b0;
        $display("write %04h <= %08h be=%b", a, d, be);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        #1;
        n_cmp++;
        if ({req_rdy, rsp_vld, init_done, sram_cen, sram_gwen} !== 5'b00011 ||
            sram_wen !== 32'hFFFF_FFFF || sram_a !== 13'h0 || sram_d !== 32'h0 ||
            rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b done=%b cen=%b gwen=%b wen=%h a=%h d=%h rdata=%h required 0 0 0 1 1 ffffffff 0 0 0",
                     req_rdy, rsp_vld, init_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (sram_cen !== 1'b1 || req_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_cycle: got cen=%b rdy=%b required 1 0", sram_cen, req_rdy);
        end
        $display("reset done, IDLE cycle");
    endtask

    task automatic test_init_abort();
        step();
        for (int i = 0; i < 'h800; i++) step();
        #1;
        n_cmp++;
        if (sram_cen !== 1'b0 || sram_a !== 13'h0800) begin
            n_bad++;
            $display("FAIL abort_point: got cen=%b a=%h required 0 0800", sram_cen, sram_a);
        end
        rst = 1'b1;
        step();
        #1;
        n_cmp++;
        if ({req_rdy, rsp_vld, init_done, sram_cen, sram_gwen} !== 5'b00011 ||
            sram_wen !== 32'hFFFF_FFFF || sram_a !== 13'h0 || sram_d !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_reset: got rdy=%b vld=%b done=%b cen=%b gwen=%b wen=%h a=%h d=%h required 0 0 0 1 1 ffffffff 0 0",
                     req_rdy, rsp_vld, init_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
        rst = 1'b0;
        $display("reset asserted at init_addr 0800");
    endtask

    task automatic test_init();
        for (int i = 0; i < 8192; i++) begin
            step();
            n_cmp++;
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 ||
                sram_a !== 13'(i) || sram_d !== 32'h0 || init_done !== 1'b0 || req_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL init_cycle_%0d: got cen=%b gwen=%b wen=%h a=%h d=%h done=%b rdy=%b required 0 0 0 %h 0 0 0",
                         i, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, init_done, req_rdy, 13'(i));
            end
        end
        step();
        n_cmp++;
        if (init_done !== 1'b1 || req_rdy !== 1'b1 || sram_cen !== 1'b1) begin
            n_bad++;
            $display("FAIL init_done: got done=%b rdy=%b cen=%b required 1 1 1", init_done, req_rdy, sram_cen);
        end
        $display("init complete, 8192 writes");
    endtask

    task automatic test_read_after_write();
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 13'h0123; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        #1;
        n_cmp++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b100 || sram_wen !== 32'h0 ||
            sram_a !== 13'h0123 || sram_d !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL write_pins: got rdy=%b cen=%b gwen=%b wen=%h a=%h d=%h required 1 0 0 0 0123 deadbeef",
                     req_rdy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
        step();
        $display("write 0123 <= deadbeef");
        req_wr = 1'b0;
        #1;
        n_cmp++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b101 || sram_wen !== 32'hFFFF_FFFF || sram_a !== 13'h0123) begin
            n_bad++;
            $display("FAIL read_pins: got rdy=%b cen=%b gwen=%b wen=%h a=%h required 1 0 1 ffffffff 0123",
                     req_rdy, sram_cen, sram_gwen, sram_wen, sram_a);
        end
        step();
        req_vld = 1'b0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0 || sram_cen !== 1'b1 || sram_a !== 13'h0123) begin
            n_bad++;
            $display("FAIL raw_latency1: got vld=%b cen=%b a=%h required 0 1 0123", rsp_vld, sram_cen, sram_a);
        end
        step();
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL raw_data: got vld=%b rdata=%h required 1 deadbeef", rsp_vld, rsp_rdata);
        end
        $display("read 0123 -> %08h", rsp_rdata);
        step();
        n_cmp++;
        if (rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_pop: got vld=%b required 0", rsp_vld);
        end
    endtask

    task automatic test_byte_enable();
        do_write(13'h0040, 32'hAABB_CCDD, 4'hF);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 13'h0040; req_wdata = 32'h1122_3344; req_be = 4'b0101;
        #1;
        n_cmp++;
        if (sram_wen !== 32'hFF00_FF00 || sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin
            n_bad++;
            $display("FAIL be_0101_wen: got wen=%h cen=%b gwen=%b required ff00ff00 0 0", sram_wen, sram_cen, sram_gwen);
        end
        step();
        $display("write 0040 <= 11223344 be=0101");
        req_wdata = 32'hFFFF_FFFF; req_be = 4'b0000;
        #1;
        n_cmp++;
        if (sram_wen !== 32'hFFFF_FFFF || sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin
            n_bad++;
            $display("FAIL be_0000_wen: got wen=%h cen=%b gwen=%b required ffffffff 0 0", sram_wen, sram_cen, sram_gwen);
        end
        step();
        $display("write 0040 <= ffffffff be=0000");
        req_wr = 1'b0;
        step();
        req_vld = 1'b0;
        step();
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hAA22_CC44) begin
            n_bad++;
            $display("FAIL be_merge: got vld=%b rdata=%h required 1 aa22cc44", rsp_vld, rsp_rdata);
        end
        $display("read 0040 -> %08h", rsp_rdata);
        step();
    endtask

    task automatic test_backpressure();
        do_write(13'h0010, 32'hC0DE_0010, 4'hF);
        do_write(13'h0011, 32'hC0DE_0011, 4'hF);
        do_write(13'h0012, 32'hC0DE_0012, 4'hF);
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 13'h0010;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept0: got rdy=%b required 1", req_rdy);
        end
        step();
        req_addr = 13'h0011;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept1: got rdy=%b required 1", req_rdy);
        end
        step();
        req_addr = 13'h0012;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b0 || rsp_vld !== 1'b1 || rsp_rdata !== 32'hC0DE_0010) begin
            n_bad++;
            $display("FAIL bp_block0: got rdy=%b vld=%b rdata=%h required 0 1 c0de0010", req_rdy, rsp_vld, rsp_rdata);
        end
        step();
        n_cmp++;
        if (req_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_block1: got rdy=%b required 0", req_rdy);
        end
        rsp_rdy = 1'b1;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b0 || rsp_rdata !== 32'hC0DE_0010) begin
            n_bad++;
            $display("FAIL bp_first_pop: got rdy=%b rdata=%h required 0 c0de0010", req_rdy, rsp_rdata);
        end
        $display("rsp -> %08h", rsp_rdata);
        step();
        n_cmp++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b1 || rsp_rdata !== 32'hC0DE_0011) begin
            n_bad++;
            $display("FAIL bp_second: got rdy=%b vld=%b rdata=%h required 1 1 c0de0011", req_rdy, rsp_vld, rsp_rdata);
        end
        $display("rsp -> %08h", rsp_rdata);
        step();
        req_vld = 1'b0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_gap: got vld=%b required 0", rsp_vld);
        end
        step();
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hC0DE_0012) begin
            n_bad++;
            $display("FAIL bp_third: got vld=%b rdata=%h required 1 c0de0012", rsp_vld, rsp_rdata);
        end
        $display("rsp -> %08h", rsp_rdata);
        step();
    endtask

    task automatic test_back_to_back();
        int got;
        logic exp_vld;
        logic [31:0] exp_data;
        got = 0;
        for (int i = 0; i < 16; i++) do_write(13'(i), 32'hB000_0000 + 32'(i), 4'hF);
        rsp_rdy = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                req_vld = 1'b1; req_wr = 1'b0; req_addr = 13'(c);
            end else begin
                req_vld = 1'b0;
            end
            #1;
            if (c < 16) begin
                n_cmp++;
                if (req_rdy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_rdy_%0d: got %b required 1", c, req_rdy);
                end
            end
            exp_vld  = (c >= 2);
            exp_data = 32'hB000_0000 + 32'(c - 2);
            n_cmp++;
            if (rsp_vld !== exp_vld || (exp_vld && rsp_rdata !== exp_data)) begin
                n_bad++;
                $display("FAIL b2b_rsp_%0d: got vld=%b rdata=%h required %b %h", c, rsp_vld, rsp_rdata, exp_vld, exp_data);
            end
            if (rsp_vld === 1'b1) begin
                got++;
                $display("b2b rsp %0d -> %08h", c, rsp_rdata);
            end
            step();
        end
        n_cmp++;
        if (got !== 16 || rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_total: got %0d responses vld=%b required 16 0", got, rsp_vld);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_rdy = 1'b1;
        test_reset();
        test_init_abort();
        test_init();
        test_read_after_write();
        test_byte_enable();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
